pc_fetch_unit: RTL and testbench

//  Instruction-fetch stage directly upstream of the control unit. Holds the PC,

---
 rtl/pc_fetch_unit.sv | 115 +++++++++++
 tb/tb_pc_fetch_unit.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: PC register, handshaked instruction fetch, next-PC selection.
// Optional build macro HALT_ON_INVALID_EN: an invalid instruction halts the core instead of retiring as a NOP.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int          FETCH_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic        inst_valid,
  input  logic        branch_eq,
  input  logic        branch_neq,
  input  logic        jump,
  input  logic        jump_reg,
  input  logic        invalid_inst,
  input  logic        alu_zero,
  input  logic [31:0] rs_data,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        halted,
  output logic        fetch_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_EXEC  = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  localparam int            CW       = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FETCH_TIMEOUT - 1);

  logic [1:0]        state;
  logic [CW-1:0]     wait_cnt;
  logic [31:0]       next_pc;
  logic              take_branch;
  logic              halt_on_inv;
  logic signed [31:0] br_off;

  assign imem_req   = (state == S_FETCH);
  assign imem_addr  = pc;
  assign inst_valid = (state == S_EXEC);
  assign halted     = (state == S_HALT);
  assign opcode     = instr[31:26];
  assign funct      = instr[5:0];
  assign pc_plus4   = pc + 32'd4;

  assign br_off      = {{14{instr[15]}}, instr[15:0], 2'b00};
  assign take_branch = (branch_eq & alu_zero) | (branch_neq & ~alu_zero);

`ifdef HALT_ON_INVALID_EN
  assign halt_on_inv = invalid_inst;
`else
  assign halt_on_inv = 1'b0;
`endif

  always_comb begin
    next_pc = pc_plus4;
    if (jump_reg)
      next_pc = {rs_data[31:2], 2'b00};
    else if (jump)
      next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
    else if (take_branch)
      next_pc = pc_plus4 + $unsigned(br_off);
`ifndef HALT_ON_INVALID_EN
    // Invalid instructions retire as NOPs regardless of decoder flow signals
    if (invalid_inst)
      next_pc = pc_plus4;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pc        <= RESET_PC;
      instr     <= '0;
      wait_cnt  <= '0;
      fetch_err <= 1'b0;
    end else begin
      case (state)
        S_IDLE: state <= S_FETCH;
        S_FETCH: begin
          if (imem_ready) begin
            instr    <= imem_rdata;
            wait_cnt <= '0;
            state    <= S_EXEC;
          end else if (wait_cnt == CNT_LAST) begin
            state     <= S_HALT;
            fetch_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        S_EXEC: begin
          if (!stall) begin
            if (halt_on_inv) begin
              state <= S_HALT;
            end else begin
              pc    <= next_pc;
              state <= S_FETCH;
            end
          end
        end
        default: state <= S_HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: fetch-address scoreboard plus directed control-flow cases.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        inst_valid;
  logic        branch_eq, branch_neq, jump, jump_reg, invalid_inst, alu_zero;
  logic [31:0] rs_data;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        halted;
  logic        fetch_err;

  int n_vec  = 0;
  int n_miss = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  pc_fetch_unit #(.RESET_PC(32'h0000_0000), .FETCH_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .stall(stall), .instr(instr), .opcode(opcode), .funct(funct),
    .inst_valid(inst_valid),
    .branch_eq(branch_eq), .branch_neq(branch_neq), .jump(jump),
    .jump_reg(jump_reg), .invalid_inst(invalid_inst), .alu_zero(alu_zero),
    .rs_data(rs_data), .pc(pc), .pc_plus4(pc_plus4),
    .halted(halted), .fetch_err(fetch_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clr_dec();
    branch_eq = 0; branch_neq = 0; jump = 0; jump_reg = 0;
    invalid_inst = 0; alu_zero = 0; rs_data = 32'h0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; imem_ready = 1'b0; imem_rdata = 32'h0; stall = 1'b0;
    clr_dec();
    repeat (2) @(negedge clk);
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_halted", {31'b0, halted}, 32'd0);
    chk("rst_ferr", {31'b0, fetch_err}, 32'd0);
    chk("rst_pc", pc, 32'h0000_0000);
    chk("rst_instr", instr, 32'h0);
    exp_q.delete();
    rst_n = 1'b1;
  endtask

  // Waits for a fetch request and checks its address against the scoreboard head.
  task automatic wait_fetch(output logic ok, output int waits);
    logic [31:0] a;
    waits = 0;
    while (!imem_req && waits < 40) begin
      @(negedge clk);
      waits++;
    end
    ok = imem_req;
    if (!ok) begin
      chk("req_timeout", 32'd0, 32'd1);
      return;
    end
    if (exp_q.size() == 0) begin
      chk("sb_empty", imem_addr, 32'hDEAD_BEEF);
      ok = 1'b0;
      return;
    end
    a = exp_q.pop_front();
    chk("imem_addr", imem_addr, a);
  endtask

  task automatic fx(input logic [31:0] word, input logic jr, input logic j, input logic beq,
                    input logic bne, input logic z, input logic inv, input logic [31:0] rs,
                    input int stall_n, input int rdy_dly, input logic [31:0] exp_next,
                    input logic halt_exp, output int waits);
    logic ok;
    logic [31:0] pc0;
    wait_fetch(ok, waits);
    if (!ok) return;
    pc0 = imem_addr;
    repeat (rdy_dly) @(negedge clk);
    if (rdy_dly > 0) chk("req_hold", {31'b0, imem_req}, 32'd1);
    imem_ready = 1'b1; imem_rdata = word;
    @(negedge clk);
    imem_ready = 1'b0; imem_rdata = $urandom;
    chk("inst_valid", {31'b0, inst_valid}, 32'd1);
    chk("instr", instr, word);
    chk("opcode", {26'b0, opcode}, {26'b0, word[31:26]});
    chk("funct", {26'b0, funct}, {26'b0, word[5:0]});
    chk("req_exec", {31'b0, imem_req}, 32'd0);
    chk("pc_plus4", pc_plus4, pc0 + 32'd4);
    jump_reg = jr; jump = j; branch_eq = beq; branch_neq = bne;
    alu_zero = z; invalid_inst = inv; rs_data = rs;
    stall = (stall_n > 0);
    for (int i = 0; i < stall_n; i++) begin
      @(negedge clk);
      chk("stall_valid", {31'b0, inst_valid}, 32'd1);
      chk("stall_pc", pc, pc0);
    end
    stall = 1'b0;
    @(negedge clk);
    clr_dec();
    if (halt_exp) begin
      chk("inv_halted", {31'b0, halted}, 32'd1);
      chk("inv_ferr", {31'b0, fetch_err}, 32'd0);
      chk("inv_pc", pc, pc0);
      chk("inv_req", {31'b0, imem_req}, 32'd0);
    end else begin
      exp_q.push_back(exp_next);
      chk("post_valid", {31'b0, inst_valid}, 32'd0);
      chk("post_halted", {31'b0, halted}, 32'd0);
    end
  endtask

  localparam logic [31:0] ADD = 32'h0022_1820;
  localparam logic [31:0] JR  = 32'h03E0_0008;

  initial begin
    int w;
    int n;
    logic ok;
    rst_n = 1'b0;
    apply_reset();
    exp_q.push_back(32'h0);

    // Straight-line stream, ready always available
    fx(ADD, 0,0,0,0,0,0, 0, 0, 0, 32'h4, 0, w);
    fx(ADD, 0,0,0,0,0,0, 0, 0, 0, 32'h8, 0, w);
    chk("b2b_wait", w, 0);
    fx(ADD, 0,0,0,0,0,0, 0, 0, 0, 32'hC, 0, w);
    chk("b2b_wait2", w, 0);

    // Branches around 0x10
    fx(32'h0800_0004, 0,1,0,0,0,0, 0, 0, 0, 32'h10, 0, w);
    fx(32'h1000_FFFE, 0,0,1,0,1,0, 0, 0, 0, 32'h0C, 0, w);
    fx(ADD,           0,0,0,0,0,0, 0, 0, 0, 32'h10, 0, w);
    fx(32'h1000_FFFE, 0,0,1,0,0,0, 0, 0, 0, 32'h14, 0, w);
    fx(32'h1400_0001, 0,0,0,1,0,0, 0, 0, 0, 32'h1C, 0, w);

    // Jumps, priority, wrap
    fx(JR,            1,0,0,0,0,0, 32'h1000_0000, 0, 0, 32'h1000_0000, 0, w);
    fx(32'h0800_0040, 0,1,0,0,0,0, 0, 0, 0, 32'h1000_0100, 0, w);
    fx(JR,            1,0,0,0,0,0, 32'h0000_0203, 0, 0, 32'h0000_0200, 0, w);
    fx(32'h0800_0300, 1,1,1,0,1,0, 32'h0000_0401, 0, 0, 32'h0000_0400, 0, w);
    fx(32'h1000_0300, 0,1,1,0,1,0, 0, 0, 0, 32'h0000_0C00, 0, w);
    fx(32'h1400_0300, 0,0,0,1,1,0, 0, 0, 0, 32'h0000_0C04, 0, w);
    fx(JR,            1,0,0,0,0,0, 32'hFFFF_FFFE, 0, 0, 32'hFFFF_FFFC, 0, w);
    fx(ADD,           0,0,0,0,0,0, 0, 0, 0, 32'h0, 0, w);

    // Stall in EXEC, then slow memory
    fx(ADD, 0,0,0,0,0,0, 0, 3, 0, 32'h4, 0, w);
    fx(ADD, 0,0,0,0,0,0, 0, 0, 3, 32'h8, 0, w);

    // Invalid instruction at pc=8
`ifdef HALT_ON_INVALID_EN
    fx(32'hFC00_0000, 0,0,0,0,0,1, 0, 0, 0, 32'h0, 1, w);
    repeat (3) @(negedge clk);
    chk("inv_sticky", {31'b0, halted}, 32'd1);
    chk("inv_pc_frz", pc, 32'h8);
    apply_reset();
    exp_q.push_back(32'h0);
    fx(ADD, 0,0,0,0,0,0, 0, 0, 0, 32'h4, 0, w);
`else
    fx(32'hFC00_0000, 0,0,0,0,0,1, 0, 0, 0, 32'hC, 0, w);
`endif

    // Asynchronous reset in the middle of FETCH
    wait_fetch(ok, w);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req", {31'b0, imem_req}, 32'd0);
    chk("arst_pc", pc, 32'h0);
    chk("arst_valid", {31'b0, inst_valid}, 32'd0);
    @(negedge clk);
    exp_q.delete();
    rst_n = 1'b1;

    // Fetch timeout
    exp_q.push_back(32'h0);
    wait_fetch(ok, w);
    n = 0;
    while (!halted && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("tmo_cycles", n, 16);
    chk("tmo_ferr", {31'b0, fetch_err}, 32'd1);
    chk("tmo_req", {31'b0, imem_req}, 32'd0);
    imem_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("tmo_sticky", {31'b0, halted}, 32'd1);
    chk("tmo_req2", {31'b0, imem_req}, 32'd0);
    chk("tmo_valid", {31'b0, inst_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
